// File: rtl/mc_pkg.sv
// mc_pkg: shared states, opcode/funct constants, ALU codes and select encodings for the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPE_EX, RTYPE_WB, BEQ_EX, ADDI_EX, ADDI_WB, JUMP
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1111;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;
  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;
  // Opcode dispatch out of DECODE; unknown opcodes fall back to FETCH
  function automatic state_t dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return MEMADR;
      OP_R:         return RTYPE_EX;
      OP_BEQ:       return BEQ_EX;
      OP_ADDI:      return ADDI_EX;
      OP_J:         return JUMP;
      default:      return FETCH;
    endcase
  endfunction
endpackage

// File: rtl/mc_control_alu_decoder.sv
// alu_decoder: maps alu_op and funct to the ALU operation code, shift-amount select and illegal-funct flag
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_con,
  output logic       shamt_sel,
  output logic       funct_illegal
);
  // funct only matters for R-type; unlisted functs fall back to ADD and flag illegal
  always_comb begin
    alu_con = alu_op == ALUOP_SUB ? ALU_SUB : ALU_ADD;
    shamt_sel = 1'b0;
    funct_illegal = 1'b0;
    if (alu_op == ALUOP_FN)
      case (funct)
        FN_ADD:  alu_con = ALU_ADD;
        FN_SUB:  alu_con = ALU_SUB;
        FN_AND:  alu_con = ALU_AND;
        FN_OR:   alu_con = ALU_OR;
        FN_SLT:  alu_con = ALU_SLT;
        FN_SLL:  begin alu_con = ALU_SLL; shamt_sel = 1'b1; end
        default: funct_illegal = 1'b1;
      endcase
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS-subset controller, Moore FSM driving datapath enables and selects
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       shamt_sel,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_con,
  output logic       instr_done,
  output logic       illegal
);
  state_t state_q, state_d, st;
  logic [1:0] alu_op;
  logic funct_illegal;
  // While reset is high the outputs look like a stalled FETCH, whatever the register holds
  assign st = reset ? FETCH : state_q;
  assign alu_op = st == RTYPE_EX ? ALUOP_FN : st == BEQ_EX ? ALUOP_SUB : ALUOP_ADD;
  alu_decoder u_alu_decoder (
    .alu_op(alu_op),
    .funct(funct),
    .alu_con(alu_con),
    .shamt_sel(shamt_sel),
    .funct_illegal(funct_illegal)
  );
  // Next-state logic; reset overrides everything, abandoning any pending memory access
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE:   state_d = dispatch(opcode);
      MEMADR:   state_d = opcode == OP_LW ? MEMRD : MEMWR;
      MEMRD:    state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:    state_d = mem_ready ? FETCH : MEMWR;
      RTYPE_EX: state_d = funct_illegal ? FETCH : RTYPE_WB;
      ADDI_EX:  state_d = ADDI_WB;
      default:  state_d = FETCH;
    endcase
    if (reset) state_d = FETCH;
  end
  // State register
  always_ff @(posedge clk) state_q <= state_d;
  // Output decode from the state; memory handshakes and the branch flag qualify the strobes
  always_comb begin
    pc_en = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_REG;
    pc_src = PC_ALU;
    instr_done = 1'b0;
    illegal = 1'b0;
    case (st)
      FETCH:    begin mem_read = 1'b1; alu_src_b = SRCB_FOUR; ir_write = mem_ready & ~reset; pc_en = mem_ready & ~reset; end
      DECODE:   begin alu_src_b = SRCB_BR; illegal = dispatch(opcode) == FETCH; end
      MEMADR,
      ADDI_EX:  begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
      MEMRD:    begin iord = 1'b1; mem_read = 1'b1; end
      MEMWR:    begin iord = 1'b1; mem_write = 1'b1; instr_done = mem_ready; end
      MEMWB:    begin reg_write = 1'b1; mem_to_reg = 1'b1; instr_done = 1'b1; end
      ADDI_WB:  begin reg_write = 1'b1; instr_done = 1'b1; end
      RTYPE_EX: begin alu_src_a = 1'b1; illegal = funct_illegal; end
      RTYPE_WB: begin reg_write = 1'b1; reg_dst = 1'b1; instr_done = 1'b1; end
      BEQ_EX:   begin alu_src_a = 1'b1; pc_src = PC_BR; pc_en = zero; instr_done = 1'b1; end
      JUMP:     begin pc_src = PC_JMP; pc_en = 1'b1; instr_done = 1'b1; end
      default:  ;
    endcase
  end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed scoreboard bench for the multicycle controller
module tb_mc_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, shamt_sel;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_con;
  logic instr_done, illegal;
  int checks = 0;
  int failures = 0;
  typedef struct { string tag; logic [19:0] e; } exp_t;
  exp_t sb[$];
  // Field order: pc_en iord mem_read mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a shamt_sel | alu_src_b | pc_src | alu_con | instr_done illegal
  localparam logic [19:0] F_WAIT  = {10'b0010000000, 2'b01, 2'b00, 4'b0010, 2'b00};
  localparam logic [19:0] F_GO    = {10'b1010100000, 2'b01, 2'b00, 4'b0010, 2'b00};
  localparam logic [19:0] DEC     = {10'b0000000000, 2'b11, 2'b00, 4'b0010, 2'b00};
  localparam logic [19:0] DEC_ILL = {10'b0000000000, 2'b11, 2'b00, 4'b0010, 2'b01};
  localparam logic [19:0] ADR     = {10'b0000000010, 2'b10, 2'b00, 4'b0010, 2'b00};
  localparam logic [19:0] RD      = {10'b0110000000, 2'b00, 2'b00, 4'b0010, 2'b00};
  localparam logic [19:0] WR_WAIT = {10'b0101000000, 2'b00, 2'b00, 4'b0010, 2'b00};
  localparam logic [19:0] WR_DONE = {10'b0101000000, 2'b00, 2'b00, 4'b0010, 2'b10};
  localparam logic [19:0] WB_MEM  = {10'b0000001100, 2'b00, 2'b00, 4'b0010, 2'b10};
  localparam logic [19:0] WB_ADDI = {10'b0000000100, 2'b00, 2'b00, 4'b0010, 2'b10};
  localparam logic [19:0] R_SUB   = {10'b0000000010, 2'b00, 2'b00, 4'b0110, 2'b00};
  localparam logic [19:0] R_SLT   = {10'b0000000010, 2'b00, 2'b00, 4'b0111, 2'b00};
  localparam logic [19:0] R_SLL   = {10'b0000000011, 2'b00, 2'b00, 4'b1111, 2'b00};
  localparam logic [19:0] R_ILL   = {10'b0000000010, 2'b00, 2'b00, 4'b0010, 2'b01};
  localparam logic [19:0] R_WB    = {10'b0000010100, 2'b00, 2'b00, 4'b0010, 2'b10};
  localparam logic [19:0] BEQ_T   = {10'b1000000010, 2'b00, 2'b01, 4'b0110, 2'b10};
  localparam logic [19:0] BEQ_N   = {10'b0000000010, 2'b00, 2'b01, 4'b0110, 2'b10};
  localparam logic [19:0] JMP     = {10'b1000000000, 2'b00, 2'b10, 4'b0010, 2'b10};

  mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .shamt_sel(shamt_sel), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_con(alu_con),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, input logic [19:0] e);
    @(posedge clk);
    #1;
    reset = r; opcode = op; funct = fn; zero = z; mem_ready = mr;
    sb.push_back('{tag, e});
  endtask

  initial begin : monitor
    exp_t x;
    logic [19:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        act = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               shamt_sel, alu_src_b, pc_src, alu_con, instr_done, illegal};
        checks++;
        if (act !== x.e) begin
          failures++;
          $display("FAIL %s outputs got=%b want=%b", x.tag, act, x.e);
        end
      end
    end
  end

  initial begin : exclusivity
    forever begin
      @(negedge clk);
      checks++;
      if ((mem_read & mem_write) | (reg_write & mem_write)) begin
        failures++;
        $display("FAIL exclusive got rd=%b wr=%b rw=%b want no overlap", mem_read, mem_write, reg_write);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    step("rst_idle",   1, 6'o00, 6'o00, 0, 0, F_WAIT);
    step("rst_ready",  1, 6'o00, 6'o00, 0, 1, F_WAIT);
    step("sub_fetch",  0, 6'b000000, 6'b100010, 0, 1, F_GO);
    step("sub_dec",    0, 6'b000000, 6'b100010, 0, 1, DEC);
    step("sub_ex",     0, 6'b000000, 6'b100010, 0, 1, R_SUB);
    step("sub_wb",     0, 6'b000000, 6'b100010, 0, 1, R_WB);
    step("lw_stall",   0, 6'b100011, 6'd0, 0, 0, F_WAIT);
    step("lw_fetch",   0, 6'b100011, 6'd0, 0, 1, F_GO);
    step("lw_dec",     0, 6'b100011, 6'd0, 0, 1, DEC);
    step("lw_adr",     0, 6'b100011, 6'd0, 0, 0, ADR);
    for (int i = 0; i < 3; i++) step("lw_rd_wait", 0, 6'b100011, 6'd0, 0, 0, RD);
    step("lw_rd_go",   0, 6'b100011, 6'd0, 0, 1, RD);
    step("lw_wb",      0, 6'b100011, 6'd0, 0, 1, WB_MEM);
    step("beq1_fetch", 0, 6'b000100, 6'd0, 1, 1, F_GO);
    step("beq1_dec",   0, 6'b000100, 6'd0, 1, 1, DEC);
    step("beq1_taken", 0, 6'b000100, 6'd0, 1, 1, BEQ_T);
    step("beq0_fetch", 0, 6'b000100, 6'd0, 0, 1, F_GO);
    step("beq0_dec",   0, 6'b000100, 6'd0, 0, 1, DEC);
    step("beq0_not",   0, 6'b000100, 6'd0, 0, 1, BEQ_N);
    step("sll_fetch",  0, 6'b000000, 6'b000000, 0, 1, F_GO);
    step("sll_dec",    0, 6'b000000, 6'b000000, 0, 1, DEC);
    step("sll_ex",     0, 6'b000000, 6'b000000, 0, 1, R_SLL);
    step("sll_wb",     0, 6'b000000, 6'b000000, 0, 1, R_WB);
    step("slt_fetch",  0, 6'b000000, 6'b101010, 0, 1, F_GO);
    step("slt_dec",    0, 6'b000000, 6'b101010, 0, 1, DEC);
    step("slt_ex",     0, 6'b000000, 6'b101010, 0, 1, R_SLT);
    step("slt_wb",     0, 6'b000000, 6'b101010, 0, 1, R_WB);
    step("ilop_fetch", 0, 6'b111111, 6'd0, 0, 1, F_GO);
    step("ilop_dec",   0, 6'b111111, 6'd0, 0, 0, DEC_ILL);
    step("ilop_back",  0, 6'b111111, 6'd0, 0, 0, F_WAIT);
    step("ilfn_fetch", 0, 6'b000000, 6'b111111, 0, 1, F_GO);
    step("ilfn_dec",   0, 6'b000000, 6'b111111, 0, 1, DEC);
    step("ilfn_ex",    0, 6'b000000, 6'b111111, 0, 0, R_ILL);
    step("ilfn_back",  0, 6'b000000, 6'b111111, 0, 0, F_WAIT);
    step("addi_fetch", 0, 6'b001000, 6'd0, 0, 1, F_GO);
    step("addi_dec",   0, 6'b001000, 6'd0, 0, 1, DEC);
    step("addi_ex",    0, 6'b001000, 6'd0, 0, 1, ADR);
    step("addi_wb",    0, 6'b001000, 6'd0, 0, 1, WB_ADDI);
    step("sw_fetch",   0, 6'b101011, 6'd0, 0, 1, F_GO);
    step("sw_dec",     0, 6'b101011, 6'd0, 0, 1, DEC);
    step("sw_adr",     0, 6'b101011, 6'd0, 0, 0, ADR);
    step("sw_wr_wait", 0, 6'b101011, 6'd0, 0, 0, WR_WAIT);
    step("sw_wr_done", 0, 6'b101011, 6'd0, 0, 1, WR_DONE);
    step("j_fetch",    0, 6'b000010, 6'd0, 0, 1, F_GO);
    step("j_dec",      0, 6'b000010, 6'd0, 0, 1, DEC);
    step("j_jump",     0, 6'b000010, 6'd0, 0, 1, JMP);
    step("rsw_fetch",  0, 6'b101011, 6'd0, 0, 1, F_GO);
    step("rsw_dec",    0, 6'b101011, 6'd0, 0, 1, DEC);
    step("rsw_adr",    0, 6'b101011, 6'd0, 0, 0, ADR);
    step("rsw_wr",     0, 6'b101011, 6'd0, 0, 0, WR_WAIT);
    step("rsw_reset",  1, 6'b101011, 6'd0, 0, 0, F_WAIT);
    step("rsw_after",  0, 6'b101011, 6'd0, 0, 0, F_WAIT);
    step("rsw_refetch",0, 6'b101011, 6'd0, 0, 1, F_GO);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0 pending", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
